periph_timer_bank: RTL and testbench

PERIPH_TIMER_BANK -- requirements
Module: periph_timer_bank

---
 rtl/periph_pkg.sv | 19 +
 rtl/timer_channel.sv | 48 ++++
 rtl/periph_timer_bank.sv | 119 +++++++++++
 tb/tb_periph_timer_bank.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_pkg.sv
// Register map constants shared by the timer bank and its channels.
// Offsets are byte offsets from BASE_ADDR or from a channel's base.
package periph_pkg;

    localparam logic [3:0] TH_OFF   = 4'h0;
    localparam logic [3:0] TL_OFF   = 4'h4;
    localparam logic [3:0] TCON_OFF = 4'h8;

    localparam logic [7:0] STATUS_OFF   = 8'h80;
    localparam logic [7:0] PRESCALE_OFF = 8'h84;

    localparam int TCON_EN  = 0;
    localparam int TCON_IRQ = 1;
    localparam int TCON_OS  = 2;

    localparam int CH_STRIDE  = 16;
    localparam int PRESCALE_W = 16;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload, live count and control register.
// Overflow is flagged combinationally so the bank can latch status.
module timer_channel
    import periph_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             wr_th,
    input  logic             wr_tl,
    input  logic             wr_tcon,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] th,
    output logic [CNT_W-1:0] tl,
    output logic [2:0]       tcon,
    output logic             ovf
);

    logic run;

    assign run = tick && tcon[TCON_EN];
    // A software TL write pre-empts the overflow in the same cycle.
    assign ovf = run && (tl == {CNT_W{1'b1}}) && !wr_tl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th)
                th <= wdata;
            if (wr_tl)
                tl <= wdata;
            else if (ovf)
                tl <= th;
            else if (run)
                tl <= tl + CNT_W'(1);
            if (wr_tcon)
                tcon <= wdata[2:0];
            else if (ovf && tcon[TCON_OS])
                tcon[TCON_EN] <= 1'b0;
        end
    end

endmodule

// File: rtl/periph_timer_bank.sv
// Bank of timer channels behind a simple rd/wr register window,
// with a shared prescaler and a write-1-to-clear status register.
module periph_timer_bank
    import periph_pkg::*;
#(
    parameter int          NUM_TIMERS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_TIMERS-1:0] irq_vec,
    output logic                  irqout
);

    logic [31:0]           off;
    logic                  ch_hit;
    logic                  st_hit;
    logic                  pre_hit;
    logic [2:0]            ch_sel;
    logic [3:0]            reg_sel;
    logic                  tick;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [NUM_TIMERS-1:0] status;
    logic [NUM_TIMERS-1:0] ovf_vec;
    logic [CNT_W-1:0]      th_a   [NUM_TIMERS];
    logic [CNT_W-1:0]      tl_a   [NUM_TIMERS];
    logic [2:0]            tcon_a [NUM_TIMERS];

    assign off     = addr - BASE_ADDR;
    assign ch_sel  = off[6:4];
    assign reg_sel = off[3:0];
    // Only word-aligned offsets inside populated channels decode.
    assign ch_hit  = (off < 32'(NUM_TIMERS * CH_STRIDE))
                     && (off[1:0] == 2'b00);
    assign st_hit  = (off == {24'b0, STATUS_OFF});
    assign pre_hit = (off == {24'b0, PRESCALE_OFF});
    assign tick    = (pcnt == prescale);

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic sel;

        assign sel = wr && ch_hit && (ch_sel == 3'(i));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .wr_th   (sel && (reg_sel == TH_OFF)),
            .wr_tl   (sel && (reg_sel == TL_OFF)),
            .wr_tcon (sel && (reg_sel == TCON_OFF)),
            .wdata   (wdata[CNT_W-1:0]),
            .th      (th_a[i]),
            .tl      (tl_a[i]),
            .tcon    (tcon_a[i]),
            .ovf     (ovf_vec[i])
        );

        assign irq_vec[i] = status[i] && tcon_a[i][TCON_IRQ];
    end

    assign irqout = |irq_vec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            pcnt     <= '0;
        end else if (wr && pre_hit) begin
            prescale <= wdata[PRESCALE_W-1:0];
            pcnt     <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PRESCALE_W'(1);
        end
    end

    // Set beats clear when both hit the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            status <= '0;
        else if (wr && st_hit)
            status <= (status & ~wdata[NUM_TIMERS-1:0]) | ovf_vec;
        else
            status <= status | ovf_vec;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (1'b1)
                ch_hit: begin
                    for (int i = 0; i < NUM_TIMERS; i++) begin
                        if (ch_sel == 3'(i)) begin
                            case (reg_sel)
                                TH_OFF:   rdata = 32'(th_a[i]);
                                TL_OFF:   rdata = 32'(tl_a[i]);
                                TCON_OFF: rdata = {29'b0, tcon_a[i]};
                                default:  rdata = '0;
                            endcase
                        end
                    end
                end
                st_hit:  rdata = 32'(status);
                pre_hit: rdata = 32'(prescale);
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_periph_timer_bank.sv
// Directed bench for periph_timer_bank with a register-level model
// checked every cycle, plus pinned literal expectations.
module tb_periph_timer_bank;

    localparam logic [31:0] B = 32'h4000_0000;

    typedef struct packed {
        logic [3:0][31:0] th;
        logic [3:0][31:0] tl;
        logic [3:0][2:0]  tcon;
        logic [3:0]       st;
        logic [15:0]      pre;
        logic [15:0]      pcnt;
    } mst_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  irq_vec;
    logic        irqout;

    mst_t        m = '0;
    int          checks = 0;
    int          errors = 0;

    logic        pin = 1'b0;
    logic [31:0] pin_exp = '0;
    string       pin_nm = "";
    logic        pin_irq = 1'b0;
    logic [3:0]  pin_vec = '0;

    always #5 clk = ~clk;

    periph_timer_bank #(
        .NUM_TIMERS(4),
        .BASE_ADDR (B),
        .CNT_W     (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd      (rd),
        .wr      (wr),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq_vec (irq_vec),
        .irqout  (irqout)
    );

    function automatic mst_t step(input mst_t s, input logic w,
                                  input logic [31:0] a,
                                  input logic [31:0] d);
        mst_t        n;
        logic        tk;
        logic [32:0] sum;
        logic [3:0]  ov;
        logic [3:0]  clr;
        n  = s;
        ov = '0;
        tk = (s.pcnt == s.pre);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] cb;
            cb = B + 32'(16 * i);
            if (tk && s.tcon[i][0] && !(w && a == cb + 32'd4)) begin
                sum = {1'b0, s.tl[i]} + 33'd1;
                if (sum[32]) begin
                    ov[i] = 1'b1;
                    n.tl[i] = s.th[i];
                    if (s.tcon[i][2])
                        n.tcon[i][0] = 1'b0;
                end else begin
                    n.tl[i] = sum[31:0];
                end
            end
            if (w && a == cb)
                n.th[i] = d;
            if (w && a == cb + 32'd4)
                n.tl[i] = d;
            if (w && a == cb + 32'd8)
                n.tcon[i] = d[2:0];
        end
        clr = (w && a == B + 32'h80) ? d[3:0] : 4'b0;
        n.st = (s.st & ~clr) | ov;
        if (w && a == B + 32'h84) begin
            n.pre  = d[15:0];
            n.pcnt = '0;
        end else begin
            n.pcnt = tk ? 16'd0 : s.pcnt + 16'd1;
        end
        return n;
    endfunction

    function automatic logic [31:0] mread(input mst_t s,
                                          input logic [31:0] a);
        logic [31:0] o;
        o = a - B;
        if (o < 32'd64 && o[1:0] == 2'b00) begin
            case (o[3:0])
                4'h0:    return s.th[o[5:4]];
                4'h4:    return s.tl[o[5:4]];
                4'h8:    return {29'b0, s.tcon[o[5:4]]};
                default: return 32'd0;
            endcase
        end
        if (o == 32'h80)
            return {28'b0, s.st};
        if (o == 32'h84)
            return {16'b0, s.pre};
        return 32'd0;
    endfunction

    function automatic logic [3:0] irqv(input mst_t s);
        logic [3:0] v;
        for (int i = 0; i < 4; i++)
            v[i] = s.st[i] & s.tcon[i][1];
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset)
                m = '0;
            else
                m = step(m, wr, addr, wdata);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("irq_vec", {28'b0, irq_vec}, {28'b0, irqv(m)});
            chk("irqout", {31'b0, irqout}, {31'b0, |irqv(m)});
            if (rd)
                chk("rdata_model", rdata, mread(m, addr));
            else
                chk("rdata_idle", rdata, 32'd0);
            if (pin)
                chk(pin_nm, rdata, pin_exp);
            if (pin_irq) begin
                chk("pin_irq_vec", {28'b0, irq_vec}, {28'b0, pin_vec});
                chk("pin_irqout", {31'b0, irqout}, {31'b0, |pin_vec});
            end
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick1();
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        rd    = 1'b0;
        addr  = a;
        wdata = d;
        tick1();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] e,
                          input string nm);
        rd      = 1'b1;
        addr    = a;
        pin     = 1'b1;
        pin_exp = e;
        pin_nm  = nm;
        tick1();
        rd  = 1'b0;
        pin = 1'b0;
    endtask

    task automatic irq_chk(input logic [3:0] v);
        pin_irq = 1'b1;
        pin_vec = v;
        tick1();
        pin_irq = 1'b0;
    endtask

    initial begin
        idle(3);
        reset = 1'b0;
        tick1();

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                rd_chk(B + 32'(16 * c + 4 * r), 32'd0, "rst_reg");
        rd_chk(B + 32'h80, 32'd0, "rst_status");
        rd_chk(B + 32'h84, 32'd0, "rst_prescale");
        irq_chk(4'b0000);

        wr_reg(B + 32'h00, 32'hFFFF_FFF0);
        wr_reg(B + 32'h04, 32'hFFFF_FFFD);
        wr_reg(B + 32'h08, 32'd3);
        idle(3);
        rd_chk(B + 32'h04, 32'hFFFF_FFF0, "ovf_reload");
        pin_irq = 1'b1;
        pin_vec = 4'b0001;
        rd_chk(B + 32'h80, 32'd1, "ovf_status");
        pin_irq = 1'b0;
        wr_reg(B + 32'h80, 32'd1);
        irq_chk(4'b0000);
        wr_reg(B + 32'h08, 32'd0);

        wr_reg(B + 32'h10, 32'h0000_1234);
        wr_reg(B + 32'h14, 32'hFFFF_FFFF);
        wr_reg(B + 32'h18, 32'd5);
        idle(1);
        rd_chk(B + 32'h14, 32'h0000_1234, "os_reload");
        rd_chk(B + 32'h18, 32'd4, "os_tcon");
        pin_irq = 1'b1;
        pin_vec = 4'b0000;
        rd_chk(B + 32'h80, 32'd2, "os_status");
        pin_irq = 1'b0;
        wr_reg(B + 32'h80, 32'd2);

        wr_reg(B + 32'h14, 32'hFFFF_FFFF);
        wr_reg(B + 32'h18, 32'd1);
        wr_reg(B + 32'h18, 32'd2);
        rd_chk(B + 32'h18, 32'd2, "tcon_wins");
        rd_chk(B + 32'h14, 32'h0000_1234, "tcon_ovf_reload");
        irq_chk(4'b0010);
        wr_reg(B + 32'h18, 32'd0);
        wr_reg(B + 32'h80, 32'd2);

        wr_reg(B + 32'h04, 32'hFFFF_FFFF);
        wr_reg(B + 32'h08, 32'd1);
        wr_reg(B + 32'h80, 32'd1);
        rd_chk(B + 32'h80, 32'd1, "w1c_set_wins");
        wr_reg(B + 32'h08, 32'd0);
        wr_reg(B + 32'h80, 32'd1);
        rd_chk(B + 32'h80, 32'd0, "w1c_clear");

        wr_reg(B + 32'h34, 32'hFFFF_FFFF);
        wr_reg(B + 32'h38, 32'd1);
        wr_reg(B + 32'h34, 32'h0000_0055);
        rd_chk(B + 32'h34, 32'h0000_0055, "tlw_no_ovf");
        rd_chk(B + 32'h80, 32'd0, "tlw_no_status");
        wr_reg(B + 32'h34, 32'h0000_ABCD);
        rd_chk(B + 32'h34, 32'h0000_ABCD, "tlw_tick");
        wr_reg(B + 32'h38, 32'd0);

        wr_reg(B + 32'h84, 32'd3);
        wr_reg(B + 32'h28, 32'd1);
        idle(19);
        rd_chk(B + 32'h24, 32'd5, "prescale_tl");
        rd_chk(B + 32'h84, 32'd3, "prescale_rd");
        wr_reg(B + 32'h28, 32'd0);

        wr_reg(B + 32'h04, 32'h0000_0100);
        wr_reg(B + 32'h08, 32'd3);
        idle(5);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        tick1();
        rd_chk(B + 32'h04, 32'd0, "mid_rst_tl");
        rd_chk(B + 32'h08, 32'd0, "mid_rst_tcon");
        rd_chk(B + 32'h80, 32'd0, "mid_rst_status");
        rd_chk(B + 32'h84, 32'd0, "mid_rst_prescale");
        irq_chk(4'b0000);
        wr_reg(B + 32'h40, 32'hFFFF_FFFF);
        rd_chk(B + 32'h40, 32'd0, "no_ch4");
        rd_chk(B + 32'h0C, 32'd0, "reserved");
        rd_chk(B + 32'h88, 32'd0, "unmapped");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
